// File: rtl/ahb_wait_mem_pkg.sv
// Shared AHB-Lite types and helpers for the wait-state memory model.
// Enumerations for transfer type, size, response and controller state, plus the byte-lane decoder.
package ahb_wait_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_e;

    // Lane mask for a 32-bit bus; alignment legality is checked separately.
    function automatic logic [3:0] lanes_f(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (hsize)
            HSIZE_BYTE: m = 4'b0001 << addr_lo;
            HSIZE_HALF: m = 4'b0011 << addr_lo;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_wait_mem_if.sv
// AHB-Lite slave-side bus bundle for ahb_wait_mem.
// Handshake: an address phase is taken on a rising edge where hready_out=1 and htrans_in[1]=1; the
// data phase then lasts until the first edge with hready_out=1, and the master holds its address phase
// (and hwdata_in) stable for as long as hready_out=0.
interface ahb_wait_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] haddr_in;
    logic [1:0]        htrans_in;
    logic              hwrite_in;
    logic [2:0]        hsize_in;
    logic [DATA_W-1:0] hwdata_in;
    logic [DATA_W-1:0] hrdata_out;
    logic              hready_out;
    logic              hresp_out;

    modport master (
        output haddr_in, htrans_in, hwrite_in, hsize_in, hwdata_in,
        input  hrdata_out, hready_out, hresp_out
    );

    modport slave (
        input  haddr_in, htrans_in, hwrite_in, hsize_in, hwdata_in,
        output hrdata_out, hready_out, hresp_out
    );
endinterface

// File: rtl/ahb_wait_mem_lfsr.sv
// Per-transfer random wait-count generator, built only when AHB_WAIT_LFSR_EN is defined.
// 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded with 16'hACE1; steps once per accepted transfer.
`ifdef AHB_WAIT_LFSR_EN
module ahb_wait_lfsr #(
    parameter int WAIT_STATES = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       step_in,
    output logic [3:0] wait_out
);
    logic [15:0] lfsr;
    logic        fb;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lfsr <= 16'hACE1;
        end else if (step_in) begin
            lfsr <= {lfsr[14:0], fb};
        end
    end

    always_comb begin
        wait_out = 4'd0;
        if (WAIT_STATES != 0) begin
            wait_out = 4'(32'(lfsr[3:0]) % (WAIT_STATES + 1));
        end
    end
endmodule
`endif

// File: rtl/ahb_wait_mem.sv
// AHB-Lite slave RAM with programmable wait states, byte-lane writes and ERROR responses.
// Define AHB_WAIT_LFSR_EN to draw each transfer's wait count from an LFSR instead of WAIT_STATES.
module ahb_wait_mem
    import ahb_wait_mem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    ahb_wait_mem_if.slave        bus,
    output state_e               dbg_state
);
    localparam int               IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0]  BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]  LIMIT_EXT = BASE_EXT + (ADDR_W + 1)'(4 * DEPTH_WORDS);

    state_e              state;
    logic [3:0]          wait_cnt;
    logic                hready_q;
    logic                hresp_q;
    logic [DATA_W-1:0]   hrdata_q;

    // Captured OKAY data phase; only writes need it, to commit on the closing edge.
    logic                d_valid;
    logic                d_write;
    logic [IDX_W-1:0]    d_idx;
    logic [3:0]          d_lanes;

    logic [DATA_W-1:0]   mem [DEPTH_WORDS];

    htrans_e             trans;
    logic                accept;
    logic                commit;
    logic                in_range;
    logic                bad_align;
    logic                a_err;
    logic [ADDR_W-1:0]   offset;
    logic [IDX_W-1:0]    a_idx;
    logic [3:0]          a_lanes;
    logic [DATA_W-1:0]   rd_word;
    logic [3:0]          wait_n;
    logic                unused_offset;

`ifdef AHB_WAIT_LFSR_EN
    ahb_wait_lfsr #(
        .WAIT_STATES (WAIT_STATES)
    ) u_lfsr (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .step_in  (accept),
        .wait_out (wait_n)
    );
`else
    assign wait_n = 4'(WAIT_STATES);
`endif

    assign unused_offset = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0]};

    always_comb begin
        trans     = htrans_e'(bus.htrans_in);
        accept    = hready_q && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
        commit    = hready_q && d_valid && d_write;
        offset    = bus.haddr_in - BASE_ADDR;
        a_idx     = offset[IDX_W+1:2];
        a_lanes   = lanes_f(bus.hsize_in, bus.haddr_in[1:0]);
        in_range  = ({1'b0, bus.haddr_in} >= BASE_EXT) && ({1'b0, bus.haddr_in} < LIMIT_EXT);
        bad_align = ((bus.hsize_in == HSIZE_HALF) && bus.haddr_in[0]) ||
                    ((bus.hsize_in == HSIZE_WORD) && (bus.haddr_in[1:0] != 2'b00));
        a_err     = !in_range || (bus.hsize_in > 3'b010) || bad_align;
        // A write closing on this edge to the same word must be visible to the read being accepted.
        rd_word   = mem[a_idx];
        if (commit && (d_idx == a_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (d_lanes[b]) begin
                    rd_word[8*b +: 8] = bus.hwdata_in[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            hrdata_q <= '0;
            d_valid  <= 1'b0;
            d_write  <= 1'b0;
            d_idx    <= '0;
            d_lanes  <= 4'd0;
        end else if (hready_q) begin
            d_valid <= 1'b0;
            if (accept && a_err) begin
                state    <= ST_ERR1;
                hready_q <= 1'b0;
                hresp_q  <= HRESP_ERROR;
                hrdata_q <= '0;
            end else if (accept) begin
                d_valid <= 1'b1;
                d_write <= bus.hwrite_in;
                d_idx   <= a_idx;
                d_lanes <= a_lanes;
                hresp_q <= HRESP_OKAY;
                if (!bus.hwrite_in) begin
                    hrdata_q <= rd_word;
                end
                if (wait_n == 4'd0) begin
                    state    <= ST_IDLE;
                    hready_q <= 1'b1;
                end else begin
                    state    <= ST_WAIT;
                    wait_cnt <= wait_n;
                    hready_q <= 1'b0;
                end
            end else begin
                state    <= ST_IDLE;
                hready_q <= 1'b1;
                hresp_q  <= HRESP_OKAY;
            end
        end else begin
            case (state)
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        hready_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    hready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (d_lanes[b]) begin
                    mem[d_idx][8*b +: 8] <= bus.hwdata_in[8*b +: 8];
                end
            end
        end
    end

    assign bus.hready_out = hready_q;
    assign bus.hresp_out  = hresp_q;
    assign bus.hrdata_out = hrdata_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_ahb_wait_mem.sv
// Directed bench for ahb_wait_mem: a zero-wait and a three-wait instance share one master stimulus;
// each scenario observes the instance selected by sel.
module tb_ahb_wait_mem;
    import ahb_wait_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m_addr;
    logic [1:0]  m_trans;
    logic        m_write;
    logic [2:0]  m_size;
    logic [31:0] m_wdata;
    logic        sel;
    state_e      st0;
    state_e      st3;

    ahb_wait_mem_if bus0 ();
    ahb_wait_mem_if bus3 ();

    assign bus0.haddr_in  = m_addr;
    assign bus0.htrans_in = m_trans;
    assign bus0.hwrite_in = m_write;
    assign bus0.hsize_in  = m_size;
    assign bus0.hwdata_in = m_wdata;
    assign bus3.haddr_in  = m_addr;
    assign bus3.htrans_in = m_trans;
    assign bus3.hwrite_in = m_write;
    assign bus3.hsize_in  = m_size;
    assign bus3.hwdata_in = m_wdata;

    ahb_wait_mem #(.WAIT_STATES(0)) dut0 (
        .clk_in(clk), .rst_in(rst), .bus(bus0), .dbg_state(st0)
    );
    ahb_wait_mem #(.WAIT_STATES(3)) dut3 (
        .clk_in(clk), .rst_in(rst), .bus(bus3), .dbg_state(st3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic rdy();
        return sel ? bus3.hready_out : bus0.hready_out;
    endfunction
    function automatic logic rsp();
        return sel ? bus3.hresp_out : bus0.hresp_out;
    endfunction
    function automatic logic [31:0] rdat();
        return sel ? bus3.hrdata_out : bus0.hrdata_out;
    endfunction
    function automatic state_e sst();
        return sel ? st3 : st0;
    endfunction

    // ---------------- driver tasks (entered and left at #1 after a rising edge) ----------------
    task automatic idle_cycles(input int n);
        m_trans = HTRANS_IDLE;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic resp);
        int guard;
        m_addr = addr; m_write = wr; m_size = size; m_trans = HTRANS_NONSEQ;
        guard = 0;
        @(negedge clk);
        while (!rdy() && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin
            n_checks++; $display("FAIL xfer_addr_timeout addr=%h", addr);
        end
        @(posedge clk); #1;
        m_trans = HTRANS_IDLE; m_wdata = wdata;
        guard = 0;
        @(negedge clk);
        while (!rdy() && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin
            n_checks++; $display("FAIL xfer_data_timeout addr=%h", addr);
        end
        rdata = rdat(); resp = rsp();
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus0.hready_out !== 1'b1) $display("FAIL rst_ready0 got=%b exp=1", bus0.hready_out); else n_pass++;
        n_checks++; if (bus3.hready_out !== 1'b1) $display("FAIL rst_ready3 got=%b exp=1", bus3.hready_out); else n_pass++;
        n_checks++; if (bus0.hresp_out !== 1'b0) $display("FAIL rst_resp0 got=%b exp=0", bus0.hresp_out); else n_pass++;
        n_checks++; if (bus3.hrdata_out !== 32'h0) $display("FAIL rst_rdata3 got=%h exp=0", bus3.hrdata_out); else n_pass++;
        n_checks++; if (st3 !== ST_IDLE) $display("FAIL rst_state3 got=%0d exp=%0d", st3, ST_IDLE); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        logic [31:0] rd;
        logic        rs;
        sel = 1'b0;
        m_addr = 32'h10; m_write = 1'b1; m_size = HSIZE_WORD; m_trans = HTRANS_NONSEQ;
        @(negedge clk);
        n_checks++; if (rdy() !== 1'b1) $display("FAIL fwd_addr_ready got=%b exp=1", rdy()); else n_pass++;
        @(posedge clk); #1;
        m_wdata = 32'hDEADBEEF; m_write = 1'b0;
        @(negedge clk);
        n_checks++; if (rdy() !== 1'b1) $display("FAIL fwd_wdata_ready got=%b exp=1", rdy()); else n_pass++;
        @(posedge clk); #1;
        m_trans = HTRANS_IDLE;
        @(negedge clk);
        n_checks++; if (rdy() !== 1'b1) $display("FAIL fwd_rd_ready got=%b exp=1", rdy()); else n_pass++;
        n_checks++; if (rsp() !== 1'b0) $display("FAIL fwd_rd_resp got=%b exp=0", rsp()); else n_pass++;
        n_checks++; if (rdat() !== 32'hDEADBEEF) $display("FAIL fwd_rdata got=%h exp=deadbeef", rdat()); else n_pass++;
        @(posedge clk); #1;
        // write to a neighbouring word, then read the first word back-to-back
        m_addr = 32'h14; m_write = 1'b1; m_trans = HTRANS_NONSEQ;
        @(posedge clk); #1;
        m_wdata = 32'h12345678; m_addr = 32'h10; m_write = 1'b0;
        @(posedge clk); #1;
        m_trans = HTRANS_IDLE;
        @(negedge clk);
        n_checks++; if (rdat() !== 32'hDEADBEEF) $display("FAIL fwd_other_word got=%h exp=deadbeef", rdat()); else n_pass++;
        @(posedge clk); #1;
        xfer(32'h14, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'h12345678) $display("FAIL fwd_ram14 got=%h exp=12345678", rd); else n_pass++;
        xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL fwd_ram10 got=%h exp=deadbeef", rd); else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        rs;
        sel = 1'b1;
        idle_cycles(6);
        xfer(32'h20, 1'b1, HSIZE_WORD, 32'hCAFEF00D, rd, rs);
        m_addr = 32'h20; m_write = 1'b0; m_size = HSIZE_WORD; m_trans = HTRANS_NONSEQ;
        @(negedge clk);
        n_checks++; if (rdy() !== 1'b1) $display("FAIL wait_addr_ready got=%b exp=1", rdy()); else n_pass++;
        @(posedge clk); #1;
        m_trans = HTRANS_IDLE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (rdy() !== (i == 3)) $display("FAIL wait_ready_c%0d got=%b exp=%b", i, rdy(), (i == 3)); else n_pass++;
            n_checks++; if (rsp() !== 1'b0) $display("FAIL wait_resp_c%0d got=%b exp=0", i, rsp()); else n_pass++;
            if (i == 0) begin
                n_checks++; if (sst() !== ST_WAIT) $display("FAIL wait_state got=%0d exp=%0d", sst(), ST_WAIT); else n_pass++;
            end
            if (i == 3) begin
                n_checks++; if (rdat() !== 32'hCAFEF00D) $display("FAIL wait_rdata got=%h exp=cafef00d", rdat()); else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        rs;
        sel = 1'b0;
        idle_cycles(6);
        xfer(32'h10, 1'b1, HSIZE_WORD, 32'h11223344, rd, rs);
        xfer(32'h13, 1'b1, HSIZE_BYTE, 32'hAAAAAAAA, rd, rs);
        xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'hAA223344) $display("FAIL lane_byte3 got=%h exp=aa223344", rd); else n_pass++;
        n_checks++; if (rs !== 1'b0) $display("FAIL lane_resp got=%b exp=0", rs); else n_pass++;
        xfer(32'h12, 1'b1, HSIZE_HALF, 32'hBEEFBEEF, rd, rs);
        xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'hBEEF3344) $display("FAIL lane_half1 got=%h exp=beef3344", rd); else n_pass++;
        xfer(32'h10, 1'b1, HSIZE_BYTE, 32'h55555555, rd, rs);
        xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'hBEEF3355) $display("FAIL lane_byte0 got=%h exp=beef3355", rd); else n_pass++;
    endtask

    task automatic test_error();
        logic [31:0] rd;
        logic        rs;
        logic [31:0] e_addr [2];
        logic        e_wr   [2];
        logic [2:0]  e_size [2];
        e_addr = '{32'h0000_1000, 32'h0000_0001};
        e_wr   = '{1'b0, 1'b1};
        e_size = '{HSIZE_WORD, HSIZE_HALF};
        sel = 1'b0;
        xfer(32'h00, 1'b1, HSIZE_WORD, 32'h01020304, rd, rs);
        for (int k = 0; k < 2; k++) begin
            m_addr = e_addr[k]; m_write = e_wr[k]; m_size = e_size[k]; m_trans = HTRANS_NONSEQ;
            @(posedge clk); #1;
            m_trans = HTRANS_IDLE; m_wdata = 32'hFFFFFFFF;
            @(negedge clk);
            n_checks++; if (rdy() !== 1'b0) $display("FAIL err%0d_c1_ready got=%b exp=0", k, rdy()); else n_pass++;
            n_checks++; if (rsp() !== 1'b1) $display("FAIL err%0d_c1_resp got=%b exp=1", k, rsp()); else n_pass++;
            n_checks++; if (sst() !== ST_ERR1) $display("FAIL err%0d_c1_state got=%0d exp=%0d", k, sst(), ST_ERR1); else n_pass++;
            @(posedge clk); #1;
            m_addr = 32'h00; m_write = 1'b0; m_size = HSIZE_WORD; m_trans = HTRANS_NONSEQ;
            @(negedge clk);
            n_checks++; if (rdy() !== 1'b1) $display("FAIL err%0d_c2_ready got=%b exp=1", k, rdy()); else n_pass++;
            n_checks++; if (rsp() !== 1'b1) $display("FAIL err%0d_c2_resp got=%b exp=1", k, rsp()); else n_pass++;
            n_checks++; if (rdat() !== 32'h0) $display("FAIL err%0d_rdata got=%h exp=0", k, rdat()); else n_pass++;
            @(posedge clk); #1;
            m_trans = HTRANS_IDLE;
            @(negedge clk);
            n_checks++; if (rdy() !== 1'b1 || rsp() !== 1'b0) $display("FAIL err%0d_next_phase got=%b/%b exp=1/0", k, rdy(), rsp()); else n_pass++;
            n_checks++; if (rdat() !== 32'h01020304) $display("FAIL err%0d_ram got=%h exp=01020304", k, rdat()); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        rs;
        sel = 1'b1;
        idle_cycles(6);
        xfer(32'h30, 1'b1, HSIZE_WORD, 32'h5A5A5A5A, rd, rs);
        xfer(32'h30, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'h5A5A5A5A) $display("FAIL rmid_pre got=%h exp=5a5a5a5a", rd); else n_pass++;
        m_addr = 32'h30; m_write = 1'b1; m_size = HSIZE_WORD; m_trans = HTRANS_NONSEQ;
        @(posedge clk); #1;
        m_trans = HTRANS_IDLE; m_wdata = 32'h0BADF00D;
        @(negedge clk);
        n_checks++; if (rdy() !== 1'b0) $display("FAIL rmid_c1_ready got=%b exp=0", rdy()); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (rdy() !== 1'b0) $display("FAIL rmid_c2_ready got=%b exp=0", rdy()); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rdy() !== 1'b1) $display("FAIL rmid_ready got=%b exp=1", rdy()); else n_pass++;
        n_checks++; if (rsp() !== 1'b0) $display("FAIL rmid_resp got=%b exp=0", rsp()); else n_pass++;
        n_checks++; if (rdat() !== 32'h0) $display("FAIL rmid_rdata got=%h exp=0", rdat()); else n_pass++;
        n_checks++; if (sst() !== ST_IDLE) $display("FAIL rmid_state got=%0d exp=%0d", sst(), ST_IDLE); else n_pass++;
        @(posedge clk); #1;
        xfer(32'h30, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'h5A5A5A5A) $display("FAIL rmid_word got=%h exp=5a5a5a5a", rd); else n_pass++;
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd;
        logic        rs;
        logic [1:0]  tv [8];
        logic [31:0] av [8];
        tv = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        av = '{32'h00, 32'h00, 32'h30, 32'h10, 32'h1000, 32'h30, 32'h00, 32'h00};
        idle_cycles(6);
        m_write = 1'b1; m_size = HSIZE_WORD; m_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) begin
            m_trans = tv[i]; m_addr = av[i];
            @(negedge clk);
            n_checks++; if (bus0.hready_out !== 1'b1 || bus0.hresp_out !== 1'b0) $display("FAIL idle0_c%0d got=%b/%b exp=1/0", i, bus0.hready_out, bus0.hresp_out); else n_pass++;
            n_checks++; if (bus3.hready_out !== 1'b1 || bus3.hresp_out !== 1'b0) $display("FAIL idle3_c%0d got=%b/%b exp=1/0", i, bus3.hready_out, bus3.hresp_out); else n_pass++;
            @(posedge clk); #1;
        end
        m_trans = HTRANS_IDLE;
        @(posedge clk); #1;
        sel = 1'b0;
        xfer(32'h00, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'h01020304) $display("FAIL idle_ram0 got=%h exp=01020304", rd); else n_pass++;
        sel = 1'b1;
        xfer(32'h30, 1'b0, HSIZE_WORD, 32'h0, rd, rs);
        n_checks++; if (rd !== 32'h5A5A5A5A) $display("FAIL idle_ram3 got=%h exp=5a5a5a5a", rd); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        sel = 1'b0;
        m_addr = 32'h0; m_trans = HTRANS_IDLE; m_write = 1'b0; m_size = HSIZE_WORD; m_wdata = 32'h0;
        test_reset();
        test_forwarding();
        test_wait_states();
        test_byte_lanes();
        test_error();
        test_reset_mid();
        test_idle_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
